// File: rtl/sub_pix_shift_lanes.sv
// Multi-lane sub-pixel shifter: each pixel is linearly interpolated toward its
// previous or next neighbour, with neighbours carried across beat boundaries.
module sub_pix_shift_lanes #(
   parameter int L = 4,
   parameter int W = 14,
   parameter int F = 8
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [L*W-1:0] sample_in,
   input  logic           sample_in_v,
   output logic           sample_in_rdy,
   input  logic           sol,
   input  logic           eol,
   input  logic [F-1:0]   fract_steps,
   input  logic           shift_dir,
   output logic [L*W-1:0] sample_out,
   output logic           sample_out_v,
   output logic           out_sol,
   output logic           out_eol,
   output logic           err_no_eol
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] HOLD  = 2'd1;
   localparam logic [1:0] FLUSH = 2'd2;

   localparam int PW = W + F + 2;
   localparam logic signed [PW-1:0] HALF = PW'(2 ** (F - 1));

   logic [1:0]     state;
   logic [L*W-1:0] hold;
   logic [W-1:0]   prev_pix;
   logic [F-1:0]   frac;
   logic           dir;
   logic           hold_sol;
   logic           err;

   logic           accept;
   logic           start;
   logic           rel_v;
   logic           rel_eol;
   logic [W-1:0]   rel_next;
   logic [L*W-1:0] prev_vec;
   logic [L*W-1:0] next_vec;
   logic [L*W-1:0] rel_nb;

   logic           s1_v;
   logic           s1_sol;
   logic           s1_eol;
   logic [L*W-1:0] s1_cen;
   logic [L*W-1:0] s1_nb;
   logic [F-1:0]   s1_frac;
   logic [L*W-1:0] s2_data;

   logic           out_v_r;
   logic           out_sol_r;
   logic           out_eol_r;
   logic [L*W-1:0] out_data;

   // Round half toward +inf, then clamp to the unsigned sample range.
   function automatic logic [W-1:0] interp(input logic [W-1:0] a,
                                           input logic [W-1:0] n,
                                           input logic [F-1:0] fr);
      logic signed [W:0]    d;
      logic signed [PW-1:0] p;
      logic signed [W+1:0]  s;
      d = $signed({1'b0, n}) - $signed({1'b0, a});
      p = PW'(d) * PW'($signed({1'b0, fr})) + HALF;
      s = $signed({2'b00, a}) + (W+2)'(p >>> F);
      if (s[W+1])
         interp = '0;
      else if (s[W])
         interp = '1;
      else
         interp = s[W-1:0];
   endfunction

   assign sample_in_rdy = reset && (state != FLUSH);
   assign accept        = sample_in_v && sample_in_rdy;
   assign start         = accept && sol;

   always_comb begin
      rel_v    = 1'b0;
      rel_eol  = 1'b0;
      rel_next = hold[(L-1)*W +: W];
      if (state == HOLD && accept) begin
         rel_v = 1'b1;
         if (sol)
            rel_eol = 1'b1;
         else
            rel_next = sample_in[W-1:0];
      end else if (state == FLUSH) begin
         rel_v   = 1'b1;
         rel_eol = 1'b1;
      end
   end

   // Whole-beat shifts give every lane its left/right neighbour at once.
   assign prev_vec = {hold[(L-1)*W-1:0], prev_pix};
   assign next_vec = {rel_next, hold[L*W-1:W]};
   assign rel_nb   = dir ? prev_vec : next_vec;

   always_comb begin
      s2_data = '0;
      for (int unsigned j = 0; j < L; j++)
         s2_data[j*W +: W] = interp(s1_cen[j*W +: W], s1_nb[j*W +: W], s1_frac);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         hold      <= '0;
         prev_pix  <= '0;
         frac      <= '0;
         dir       <= 1'b0;
         hold_sol  <= 1'b0;
         err       <= 1'b0;
         s1_v      <= 1'b0;
         s1_sol    <= 1'b0;
         s1_eol    <= 1'b0;
         s1_cen    <= '0;
         s1_nb     <= '0;
         s1_frac   <= '0;
         out_v_r   <= 1'b0;
         out_sol_r <= 1'b0;
         out_eol_r <= 1'b0;
         out_data  <= '0;
      end else begin
         // A sol in HOLD releases the old line (above) and opens the new one here.
         if (start) begin
            hold     <= sample_in;
            prev_pix <= sample_in[W-1:0];
            frac     <= fract_steps;
            dir      <= shift_dir;
            hold_sol <= 1'b1;
            state    <= eol ? FLUSH : HOLD;
         end else if (state == HOLD && accept) begin
            prev_pix <= hold[(L-1)*W +: W];
            hold     <= sample_in;
            hold_sol <= 1'b0;
            state    <= eol ? FLUSH : HOLD;
         end else if (state == FLUSH) begin
            state <= IDLE;
         end
         if (state == HOLD && start)
            err <= 1'b1;

         s1_v <= rel_v;
         if (rel_v) begin
            s1_cen  <= hold;
            s1_nb   <= rel_nb;
            s1_frac <= frac;
            s1_sol  <= hold_sol;
            s1_eol  <= rel_eol;
         end

         out_v_r   <= s1_v;
         out_sol_r <= s1_v && s1_sol;
         out_eol_r <= s1_v && s1_eol;
         if (s1_v)
            out_data <= s2_data;
      end
   end

   assign sample_out   = reset ? out_data : '0;
   assign sample_out_v = reset && out_v_r;
   assign out_sol      = reset && out_sol_r;
   assign out_eol      = reset && out_eol_r;
   assign err_no_eol   = reset && err;

endmodule

// File: tb/tb_sub_pix_shift_lanes.sv
// Directed bench for sub_pix_shift_lanes: a line-level interpolation model
// feeds an expectation queue checked every cycle, plus literal beat checks.
module tb_sub_pix_shift_lanes;

   localparam int L = 4;
   localparam int W = 14;
   localparam int F = 8;

   logic           clk;
   logic           reset;
   logic [L*W-1:0] sample_in;
   logic           sample_in_v;
   logic           sample_in_rdy;
   logic           sol;
   logic           eol;
   logic [F-1:0]   fract_steps;
   logic           shift_dir;
   logic [L*W-1:0] sample_out;
   logic           sample_out_v;
   logic           out_sol;
   logic           out_eol;
   logic           err_no_eol;

   sub_pix_shift_lanes #(.L(L), .W(W), .F(F)) dut (
      .clk          (clk),
      .reset        (reset),
      .sample_in    (sample_in),
      .sample_in_v  (sample_in_v),
      .sample_in_rdy(sample_in_rdy),
      .sol          (sol),
      .eol          (eol),
      .fract_steps  (fract_steps),
      .shift_dir    (shift_dir),
      .sample_out   (sample_out),
      .sample_out_v (sample_out_v),
      .out_sol      (out_sol),
      .out_eol      (out_eol),
      .err_no_eol   (err_no_eol)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [L*W-1:0] d;
      bit             s;
      bit             e;
   } beat_t;

   int    n_checks = 0;
   int    n_fail   = 0;
   beat_t expq[$];
   beat_t seen[$];
   beat_t g0[$];

   int    line_pix[$];
   int    held_k;
   bit    held_first;
   bit    line_open = 1'b0;
   int    lfrac;
   int    ldir;
   bit    err_exp = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [L*W-1:0] pk(input int a, input int b, input int c, input int d);
      pk = {W'(d), W'(c), W'(b), W'(a)};
   endfunction

   // A + round(fraction of the way to N), half rounds up, clamped to W bits.
   function automatic int interp_m(input int a, input int n, input int fr);
      real v;
      int  r;
      v = real'(a) + $floor(real'((n - a) * fr) / (2.0 ** F) + 0.5);
      r = int'(v);
      if (r < 0) r = 0;
      if (r > (1 << W) - 1) r = (1 << W) - 1;
      return r;
   endfunction

   function automatic void emit(input bit is_eol);
      beat_t b;
      int idx, pi, ni, n;
      b.d = '0;
      for (int j = 0; j < L; j++) begin
         idx = held_k * L + j;
         pi  = (idx > 0) ? idx - 1 : 0;
         ni  = (idx + 1 < line_pix.size()) ? idx + 1 : idx;
         n   = ldir ? line_pix[pi] : line_pix[ni];
         b.d[j*W +: W] = W'(interp_m(line_pix[idx], n, lfrac));
      end
      b.s = held_first;
      b.e = is_eol;
      expq.push_back(b);
      held_first = 1'b0;
      held_k++;
   endfunction

   function automatic void push_pix(input logic [L*W-1:0] b);
      for (int j = 0; j < L; j++)
         line_pix.push_back(int'(b[j*W +: W]));
   endfunction

   function automatic void model_accept(input logic [L*W-1:0] b, input bit s, input bit e,
                                        input int fr, input int dr);
      if (s) begin
         if (line_open) begin
            emit(1'b1);
            err_exp = 1'b1;
         end
         line_pix.delete();
         push_pix(b);
         lfrac      = fr;
         ldir       = dr;
         held_k     = 0;
         held_first = 1'b1;
         line_open  = 1'b1;
         if (e) begin
            emit(1'b1);
            line_open = 1'b0;
         end
      end else if (line_open) begin
         push_pix(b);
         emit(1'b0);
         if (e) begin
            emit(1'b1);
            line_open = 1'b0;
         end
      end
   endfunction

   function automatic void model_reset();
      expq.delete();
      line_pix.delete();
      line_open = 1'b0;
      err_exp   = 1'b0;
   endfunction

   // Every cycle: reset forces zeros; otherwise outputs must follow the model queue.
   always @(negedge clk) begin
      if (!reset) begin
         check("reset_outputs",
               {58'd0, sample_in_rdy, sample_out_v, out_sol, out_eol, err_no_eol, |sample_out},
               64'd0);
      end else begin
         check("err_no_eol", err_no_eol, err_exp);
         if (sample_out_v) begin
            beat_t act;
            act.d = sample_out;
            act.s = out_sol;
            act.e = out_eol;
            seen.push_back(act);
            if (expq.size() == 0) begin
               check("unexpected_out", 1, 0);
            end else begin
               beat_t x;
               x = expq.pop_front();
               check("out_data", act.d, x.d);
               check("out_sol_eol", {act.s, act.e}, {x.s, x.e});
            end
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 of the accepting edge.
   task automatic drive_beat(input logic [L*W-1:0] b, input bit s, input bit e,
                             input int fr, input int dr);
      int n;
      sample_in   = b;
      sample_in_v = 1'b1;
      sol         = s;
      eol         = e;
      fract_steps = F'(fr);
      shift_dir   = dr[0];
      n = 0;
      @(negedge clk);
      while (!sample_in_rdy && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!sample_in_rdy) begin
         check("rdy_timeout", 0, 1);
         sample_in_v = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      sample_in_v = 1'b0;
      sol         = 1'b0;
      eol         = 1'b0;
      model_accept(b, s, e, fr, dr);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_seen(input string nm, input int idx, input logic [L*W-1:0] exp,
                             input bit s, input bit e);
      check({nm, "_present"}, 64'(idx < seen.size()), 64'd1);
      if (idx < seen.size()) begin
         check({nm, "_data"}, seen[idx].d, exp);
         check({nm, "_flags"}, {seen[idx].s, seen[idx].e}, {s, e});
      end
   endtask

   task automatic ramp_line(input int gap);
      for (int b = 0; b < 3; b++) begin
         int p0 = ((b*4+0) * (b*4+0) * 97) % 16384;
         int p1 = ((b*4+1) * (b*4+1) * 97) % 16384;
         int p2 = ((b*4+2) * (b*4+2) * 97) % 16384;
         int p3 = ((b*4+3) * (b*4+3) * 97) % 16384;
         drive_beat(pk(p0, p1, p2, p3), b == 0, b == 2, 77, 0);
         if (b < 2) idle(gap);
      end
      idle(6);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
      $fatal(1);
   end

   initial begin
      reset       = 1'b0;
      sample_in   = '0;
      sample_in_v = 1'b0;
      sol         = 1'b0;
      eol         = 1'b0;
      fract_steps = '0;
      shift_dir   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("post_reset_rdy", sample_in_rdy, 1);
      check("post_reset_v", sample_out_v, 0);
      check("post_reset_err", err_no_eol, 0);

      // Two-beat line toward next neighbour.
      seen.delete();
      drive_beat(pk(0, 100, 200, 300), 1, 0, 128, 0);
      drive_beat(pk(400, 500, 600, 700), 0, 1, 128, 0);
      check("rdy_flush_low", sample_in_rdy, 0);
      idle(1);
      check("rdy_after_flush", sample_in_rdy, 1);
      idle(5);
      check("t1_count", seen.size(), 2);
      check_seen("t1_b0", 0, pk(50, 150, 250, 350), 1, 0);
      check_seen("t1_b1", 1, pk(450, 550, 650, 700), 0, 1);

      // Same line toward previous neighbour.
      seen.delete();
      drive_beat(pk(0, 100, 200, 300), 1, 0, 128, 1);
      drive_beat(pk(400, 500, 600, 700), 0, 1, 128, 1);
      idle(6);
      check_seen("t2_b0", 0, pk(0, 50, 150, 250), 1, 0);
      check_seen("t2_b1", 1, pk(350, 450, 550, 650), 0, 1);

      // Zero step is a passthrough.
      seen.delete();
      drive_beat(pk(0, 100, 200, 300), 1, 0, 0, 0);
      drive_beat(pk(400, 500, 600, 700), 0, 1, 0, 0);
      idle(6);
      check_seen("t3_b0", 0, pk(0, 100, 200, 300), 1, 0);
      check_seen("t3_b1", 1, pk(400, 500, 600, 700), 0, 1);

      // Single-beat line: output exactly two cycles after the FLUSH cycle.
      seen.delete();
      drive_beat(pk(1000, 2000, 3000, 4000), 1, 1, 64, 0);
      check("t4_rdy_flush", sample_in_rdy, 0);
      @(negedge clk);
      check("t4_v_flush_cycle", sample_out_v, 0);
      @(negedge clk);
      check("t4_rdy_back", sample_in_rdy, 1);
      check("t4_v_plus1", sample_out_v, 0);
      @(negedge clk);
      check("t4_v_plus2", {sample_out_v, out_sol, out_eol}, 3'b111);
      @(negedge clk);
      check("t4_v_plus3", sample_out_v, 0);
      @(posedge clk);
      #1;
      idle(3);
      check_seen("t4_b0", 0, pk(1250, 2250, 3250, 4000), 1, 1);

      // Rounding and top-of-range.
      seen.delete();
      drive_beat(pk(0, 1, 0, 0), 1, 1, 128, 0);
      idle(1);
      drive_beat(pk(16383, 16383, 16383, 16383), 1, 1, 255, 0);
      idle(6);
      check_seen("t5_round", 0, pk(1, 1, 0, 0), 1, 1);
      check_seen("t5_top", 1, pk(16383, 16383, 16383, 16383), 1, 1);

      // Beat with no open line is dropped.
      seen.delete();
      drive_beat(pk(5, 5, 5, 5), 0, 0, 128, 0);
      idle(6);
      check("t6_dropped", seen.size(), 0);

      // Valid gaps must not change the values.
      seen.delete();
      ramp_line(0);
      g0 = seen;
      seen.delete();
      ramp_line(3);
      check("t7_count", seen.size(), g0.size());
      check("t7_count_lit", g0.size(), 3);
      for (int i = 0; i < g0.size() && i < seen.size(); i++) begin
         check("t7_gap_data", seen[i].d, g0[i].d);
         check("t7_gap_flags", {seen[i].s, seen[i].e}, {g0[i].s, g0[i].e});
      end

      // sol while a line is open closes it as eol and latches the error.
      seen.delete();
      check("t8_err_before", err_no_eol, 0);
      drive_beat(pk(10, 20, 30, 40), 1, 0, 128, 0);
      drive_beat(pk(50, 60, 70, 80), 0, 0, 128, 0);
      drive_beat(pk(100, 200, 300, 400), 1, 1, 128, 1);
      idle(6);
      check("t8_err_latched", err_no_eol, 1);
      check_seen("t8_b0", 0, pk(15, 25, 35, 45), 1, 0);
      check_seen("t8_b1", 1, pk(55, 65, 75, 80), 0, 1);
      check_seen("t8_b2", 2, pk(100, 150, 250, 350), 1, 1);

      // Reset mid-line discards everything in flight.
      seen.delete();
      drive_beat(pk(1, 2, 3, 4), 1, 0, 128, 0);
      drive_beat(pk(5, 6, 7, 8), 0, 0, 128, 0);
      reset = 1'b0;
      model_reset();
      idle(1);
      reset = 1'b1;
      idle(6);
      check("t9_no_stale", seen.size(), 0);
      check("t9_err_cleared", err_no_eol, 0);
      drive_beat(pk(0, 100, 200, 300), 1, 0, 128, 0);
      drive_beat(pk(400, 500, 600, 700), 0, 1, 128, 0);
      idle(6);
      check_seen("t9_b0", 0, pk(50, 150, 250, 350), 1, 0);
      check_seen("t9_b1", 1, pk(450, 550, 650, 700), 0, 1);

      idle(4);
      check("pending_expected", expq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
